eth_mac_tx_arbiter: RTL
=======================

# eth_mac_tx_arbiter

Packet-granular round-robin arbiter that shares the 8-bit AXI-stream transmit input of the 10/100 MII MAC between `S_COUNT` requesters. It sits in the MAC `tx_clk` domain, directly in front of the MAC `tx_axis_*` port. A granted source keeps the MAC until its `tlast` beat. A stall watchdog aborts a source that stops mid-packet, so one broken requester cannot hold the MAC indefinitely.

## Interface
Parameters:
- `S_COUNT`, 4: number of requesters, 2..16.
- `TIMEOUT`, 1024: number of consecutive mid-packet source-stall cycles before abort. 0 disables the watchdog.

Ports:
- `clk` in 1: MAC transmit clock. All logic is on the rising edge.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `s_axis_tdata` in `S_COUNT*8`: source data; source i uses bits [8i+7:8i].
- `s_axis_tvalid` in `S_COUNT`: per-source valid.
- `s_axis_tready` out `S_COUNT`: per-source ready.
- `s_axis_tlast` in `S_COUNT`: per-source end of packet.
- `s_axis_tuser` in `S_COUNT`: per-source bad-frame flag, forwarded unchanged.
- `m_axis_tdata` out 8: to MAC `tx_axis_tdata`.
- `m_axis_tvalid` out 1: to MAC.
- `m_axis_tready` in 1: from MAC.
- `m_axis_tlast` out 1: to MAC.
- `m_axis_tuser` out 1: to MAC; 1 marks the frame as errored.
- `grant_valid` out 1: high while a source owns the MAC (PASS or ABORT or DRAIN).
- `grant_index` out `$clog2(S_COUNT)`: index of the current or most recent grant.
- `timeout_abort` out 1: one-cycle pulse when the abort beat is accepted by the MAC.

## Operation
States:
- **IDLE**:
  - All `s_axis_tready` = 0 and `m_axis_tvalid` = 0.
  - If any `s_axis_tvalid` is high, choose the first requester searching upward from `(last+1) mod S_COUNT`.
  - Register it as `grant_index` and `last`, then go to PASS.
- **PASS**: combinational pass-through of the granted source only.
  - `m_axis_* = s_axis_*[g]` and `s_axis_tready[g] = m_axis_tready`; all other sources see tready = 0.
  - A handshake with `tlast` = 1 goes to IDLE.
  - Watchdog counter:
    - Clears on every source handshake and on entry to PASS.
    - Increments on each cycle where `s_axis_tvalid[g]` = 0.
    - Does not count MAC backpressure (`tvalid` = 1, `tready` = 0).
  - When the counter reaches `TIMEOUT` and `TIMEOUT` != 0, go to ABORT.
- **ABORT**:
  - Drive `m_axis_tvalid` = 1, `tdata` = 0x00, `tlast` = 1, `tuser` = 1; source tready = 0.
  - Hold these values until `m_axis_tready` is high.
  - On acceptance, pulse `timeout_abort` and go to DRAIN.
- **DRAIN**:
  - `s_axis_tready[g]` = 1 and `m_axis_tvalid` = 0; source beats are discarded.
  - An accepted source `tlast` goes to IDLE.
- Width rule: the watchdog counter is `$clog2(TIMEOUT+1)` bits and saturates, so it never wraps.
- Simultaneous events:
  - A source beat arriving on the cycle the counter would reach `TIMEOUT` clears the counter; no abort is issued.
  - Packets of length 1 (`tlast` on the first beat) are legal.
- A source that drops `tvalid` while not granted loses nothing, because no arbitration state is held for non-granted sources.

## Timing
- Reset (`rst_n` = 0 at an edge): state = IDLE, `last` = `S_COUNT-1` so source 0 has first priority.
- Reset values of outputs: `grant_index` = 0, `grant_valid` = 0, counter = 0, `timeout_abort` = 0, all `s_axis_tready` = 0, `m_axis_tvalid`/`tlast`/`tuser` = 0, `m_axis_tdata` = 0.
- Reset mid-packet: the transfer is abandoned immediately and no abort beat is sent. The MAC shares this reset.
- Grant latency: `tvalid` seen in IDLE at cycle N gives the first `m_axis_tvalid` at cycle N+1.
- Packet turnaround: at least one IDLE cycle between a `tlast` handshake and the next packet's first beat.
- PASS forwards with 0 latency. There is no buffering, and throughput equals the MAC's.
- Abort timing: with the source stalled from cycle K, the abort beat is presented at cycle K+`TIMEOUT`+1 at the earliest.

## Test plan
- Sources 0 and 2 each send a 3-byte packet (0x11,0x22,0x33 and 0xA1,0xA2,0xA3), tvalid raised together after reset:
  - Source 0 packet forwards first, then one idle cycle, then source 2.
  - `grant_index` reads 0 then 2.
- All 4 sources request continuously with 1-byte packets: grant order is 0,1,2,3,0 and each `m_axis_tlast` = 1.
- With `TIMEOUT` = 8, source 1 sends 2 bytes and then holds tvalid = 0:
  - After 8 stall cycles the MAC receives 0x00 with tlast = 1 and tuser = 1, and `timeout_abort` pulses once.
  - The source's next 3 bytes plus tlast are dropped, then IDLE.
- MAC tready = 0 for 20 cycles mid-packet with `TIMEOUT` = 8: no abort occurs, and data resumes intact.
- With source tuser = 1 on `tlast`, the bad-frame flag passes through to `m_axis_tuser` = 1.
- `rst_n` pulsed low for 1 cycle during PASS: the next cycle shows IDLE, all tready = 0, and source 0 has priority again.

Source files
------------

// File: rtl/eth_mac_tx_arbiter_if.sv
// AXI-stream bundle for the MAC transmit arbiter: S_COUNT source lanes plus the single
// MAC-facing lane. The arbiter takes the slave view; whoever drives sources/MAC takes master.
interface eth_mac_tx_arbiter_if #(
  parameter int unsigned S_COUNT = 4
);
  logic [S_COUNT*8-1:0] s_axis_tdata;
  logic [S_COUNT-1:0]   s_axis_tvalid;
  logic [S_COUNT-1:0]   s_axis_tready;
  logic [S_COUNT-1:0]   s_axis_tlast;
  logic [S_COUNT-1:0]   s_axis_tuser;

  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic                 m_axis_tuser;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    output s_axis_tlast,
    output s_axis_tuser,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    input  m_axis_tuser
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    input  s_axis_tlast,
    input  s_axis_tuser,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    output m_axis_tuser
  );
endinterface

// File: rtl/eth_mac_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the MII MAC transmit port, with a
// mid-packet stall watchdog that terminates a stuck frame with an errored abort beat.
module eth_mac_tx_arbiter #(
  parameter int unsigned S_COUNT = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  eth_mac_tx_arbiter_if.slave        bus,
  output logic                       grant_valid,
  output logic [$clog2(S_COUNT)-1:0] grant_index,
  output logic                       timeout_abort
);

  localparam int unsigned IdxW = $clog2(S_COUNT);
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPass  = 2'd1;
  localparam logic [1:0] StAbort = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [7:0]         src_data [S_COUNT];
  logic               src_valid;
  logic               src_last;
  logic               src_user;

  logic               pick_found;
  logic [IdxW-1:0]    pick_idx;

  logic [S_COUNT-1:0] s_ready;
  logic [7:0]         m_data;
  logic               m_valid;
  logic               m_last;
  logic               m_user;
  logic               abort_pulse;

  for (genvar i = 0; i < S_COUNT; i++) begin : g_lane
    assign src_data[i] = bus.s_axis_tdata[i*8 +: 8];
  end

  assign src_valid = bus.s_axis_tvalid[grant_q];
  assign src_last  = bus.s_axis_tlast[grant_q];
  assign src_user  = bus.s_axis_tuser[grant_q];

  // Round-robin search: indices above last first, then wrap to 0..last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      if (!pick_found && bus.s_axis_tvalid[i] && (IdxW'(i) > last_q)) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(i);
      end
    end
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      if (!pick_found && bus.s_axis_tvalid[i] && (IdxW'(i) <= last_q)) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    s_ready     = '0;
    m_data      = 8'h00;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_user      = 1'b0;
    abort_pulse = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          state_d = StPass;
        end
      end

      StPass: begin
        m_data           = src_data[grant_q];
        m_valid          = src_valid;
        m_last           = src_last;
        m_user           = src_user;
        s_ready[grant_q] = bus.m_axis_tready;
        if (src_valid && bus.m_axis_tready) begin
          cnt_d = '0;
          if (src_last) begin
            state_d = StIdle;
          end
        end else if (!src_valid) begin
          // Only source-side silence counts; MAC backpressure holds the counter.
          if ((TIMEOUT != 0) && (cnt_q == CntLimit)) begin
            state_d = StAbort;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StAbort: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_user  = 1'b1;
        if (bus.m_axis_tready) begin
          abort_pulse = 1'b1;
          state_d     = StDrain;
        end
      end

      StDrain: begin
        s_ready[grant_q] = 1'b1;
        if (src_valid && src_last) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(S_COUNT - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tdata  = m_data;
  assign bus.m_axis_tvalid = m_valid;
  assign bus.m_axis_tlast  = m_last;
  assign bus.m_axis_tuser  = m_user;

  assign grant_valid   = (state_q != StIdle);
  assign grant_index   = grant_q;
  assign timeout_abort = abort_pulse;

endmodule
